rambam_key_sequencer: RTL and testbench
=======================================

Name: rambam_key_sequencer

Overview:
Round-key sequencer that sits directly upstream of key_expansion and downstream of the key-load interface.
- Holds the current masked round key in redundant form (4x4 bytes of 8+d bits) and feeds it to key_expansion.
- Drives key_expansion's drdy_i and first_round, and captures its out on drdy_o.
- Presents one round key per round to the AddRoundKey datapath, with a request/valid handshake and a round index.

Parameters:
d, `d, redundancy bits per byte; byte width is 8+d.
NR, 10, number of expansions per key; round keys 0..NR are issued.

Ports:
clk  in  1  clock
rst  in  1  reset
key_i  in  [3:0][3:0][0:7+d]  initial masked key (round-0 key)
key_load_i  in  1  load key_i and start a new schedule
rk_o  out  [3:0][3:0][0:7+d]  current round key
rk_valid_o  out  1  rk_o holds a valid key for round rk_round_o
rk_round_o  out  4  round index of rk_o, 0..NR
rk_req_i  in  1  one-cycle pulse: current round key consumed
done_o  out  1  one-cycle pulse after round-NR key is consumed
err_o  out  1  sticky protocol error
ke_in_o  out  [3:0][3:0][0:7+d]  to key_expansion.in
ke_drdy_o  out  1  to key_expansion.drdy_i
ke_first_round_o  out  1  to key_expansion.first_round
ke_out_i  in  [3:0][3:0][0:7+d]  from key_expansion.out
ke_drdy_i  in  1  from key_expansion.drdy_o

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. Reset state is IDLE, with every output 0: rk_o, rk_valid_o, rk_round_o, done_o, err_o, ke_drdy_o, ke_first_round_o, and the key register.
- State machine, states IDLE, READY, EXPAND:
  - IDLE: on key_load_i, register key_i, set round=0, go to READY. rk_valid_o=1 from the next cycle (1-cycle load latency).
  - READY (rk_valid_o=1):
    - On rk_req_i with round<NR: pulse ke_drdy_o for exactly 1 cycle (the same cycle the state registers EXPAND), drop rk_valid_o, go to EXPAND.
    - On rk_req_i with round==NR: done_o=1 for 1 cycle, rk_valid_o=0, go to IDLE.
  - EXPAND: wait for ke_drdy_i. In that cycle's edge, capture ke_out_i into the key register, increment round, go to READY, and assert rk_valid_o next cycle.
- Key path wiring: ke_in_o = key register (combinational, stable throughout EXPAND). rk_o = key register.
- ke_first_round_o = (round==0), registered. It must be high while key_expansion is idle before the first ke_drdy_o so that its rcon resets.
- Latency per round = key_expansion latency + 1 cycle capture. No combinational path from ke_drdy_i to rk_valid_o.
- Boundary conditions:
  - key_load_i in READY: abort the current schedule and reload; round=0.
  - key_load_i in EXPAND: ignored and err_o set, because the in-flight expansion cannot be cancelled.
  - rk_req_i outside READY: ignored and err_o set.
  - ke_drdy_i outside EXPAND: ignored and err_o set.
  - key_load_i and rk_req_i in the same READY cycle: load wins, no ke_drdy_o.
  - err_o clears only on rst.
  - Reset mid-EXPAND: return to IDLE. key_expansion shares rst, so no stale drdy is possible.
- rk_round_o saturates at NR and never wraps.

Optional Feature:
KEY_PREFETCH_EN
- Defined:
  - Expansion of round r+1 starts automatically one cycle after round r becomes valid.
  - The result is captured into a shadow register with a flag next_valid.
  - rk_req_i in READY with next_valid=1 swaps the shadow into the key register in 1 cycle, with no EXPAND wait. rk_valid_o stays high, rk_round_o increments, and the next prefetch starts.
  - If next_valid=0, behaviour falls back to EXPAND.
  - ke_in_o = key register.
  - key_load_i during an in-flight prefetch: the load is accepted and the returning result is discarded without setting err_o.
- Undefined: behaviour exactly as above, with no shadow register.

Decomposition:
- Shared package holds:
  - typedef key_state_t {KSEQ_IDLE, KSEQ_READY, KSEQ_EXPAND}
  - typedef round_key_t = [3:0][3:0][0:7+d]
  - localparam NR_DEFAULT=10
- One sub-module, round_key_register: enable/load register of round_key_t with async reset. It is instantiated once for the key and once for the shadow when KEY_PREFETCH_EN is defined.

Test Plan:
Use a stub key_expansion with fixed 6-cycle latency that returns in+1 per byte; d=2, NR=10.
1. Load key of all bytes 10'h005, then 11 rk_req_i pulses -> rk_round_o 0..10, rk_o bytes 0x005..0x00F, done_o one pulse after the 11th req, IDLE, err_o=0.
2. Latency check -> rk_valid_o rises exactly 7 cycles after each rk_req_i. ke_drdy_o high exactly 1 cycle. ke_first_round_o=1 only before the first expansion.
3. key_load_i during EXPAND -> ignored, err_o=1, schedule continues. key_load_i in READY at round 4 -> round 0, rk_o = new key_i.
4. rk_req_i in IDLE, and spurious ke_drdy_i in READY -> no state change, err_o=1 until rst.
5. Assert rst mid-EXPAND at round 3 -> all outputs 0 immediately. A new load then restarts cleanly with ke_first_round_o=1.
6. With KEY_PREFETCH_EN defined and back-to-back reqs spaced 8 cycles apart -> rk_valid_o never drops, and rk_o advances 1 cycle after each req.

Source files
------------

// File: rtl/rambam_key_sequencer_pkg.sv
// rambam_key_sequencer_pkg: shared types for the round-key sequencer; byte redundancy taken from macro `D (default 2)
`ifndef D
`define D 2
`endif
package rambam_key_sequencer_pkg;
  localparam int d = `D;
  localparam int NR_DEFAULT = 10;
  typedef logic [3:0][3:0][0:7+d] round_key_t;
  typedef enum logic [1:0] {KSEQ_IDLE, KSEQ_READY, KSEQ_EXPAND} key_state_t;
endpackage

// File: rtl/rambam_key_sequencer_round_key_register.sv
// round_key_register: enable-loaded round key register with async reset
module round_key_register
  import rambam_key_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  round_key_t val,
  output round_key_t q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= val;
endmodule

// File: rtl/rambam_key_sequencer.sv
// rambam_key_sequencer: issues one masked round key per round, driving key_expansion
// KEY_PREFETCH_EN adds a shadow key so the next expansion runs ahead of the consumer.
module rambam_key_sequencer
  import rambam_key_sequencer_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  round_key_t key_i,
  input  logic       key_load_i,
  output round_key_t rk_o,
  output logic       rk_valid_o,
  output logic [3:0] rk_round_o,
  input  logic       rk_req_i,
  output logic       done_o,
  output logic       err_o,
  output round_key_t ke_in_o,
  output logic       ke_drdy_o,
  output logic       ke_first_round_o,
  input  round_key_t ke_out_i,
  input  logic       ke_drdy_i
);
  localparam logic [3:0] NR4 = 4'(NR);
  key_state_t state, state_d;
  logic [3:0] round, round_d;
  logic       err, err_d, done, done_d, drdy, drdy_d, first;
  logic       key_en, busy, discard, nv, arrive;
  round_key_t key_q, key_val, shadow;
`ifdef KEY_PREFETCH_EN
  localparam bit PF = 1'b1;
  logic sh_en;
  assign sh_en = state == KSEQ_READY && arrive && !key_load_i && !rk_req_i;
  // busy tracks any expansion in flight; discard marks one orphaned by a reload
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy    <= 1'b0;
      discard <= 1'b0;
      nv      <= 1'b0;
    end else begin
      busy    <= drdy_d | (busy & ~ke_drdy_i);
      discard <= busy & ~ke_drdy_i & (discard | (state == KSEQ_READY & key_load_i));
      nv      <= (state == KSEQ_READY && (key_load_i || rk_req_i)) ? 1'b0 : nv | sh_en;
    end
  round_key_register u_shadow (.clk(clk), .rst(rst), .en(sh_en), .val(ke_out_i), .q(shadow));
`else
  localparam bit PF = 1'b0;
  assign busy    = state == KSEQ_EXPAND;
  assign discard = 1'b0;
  assign nv      = 1'b0;
  assign shadow  = '0;
`endif
  assign arrive = ke_drdy_i & busy & ~discard;
  round_key_register u_key (.clk(clk), .rst(rst), .en(key_en), .val(key_val), .q(key_q));
  always_comb begin
    state_d = state;
    round_d = round;
    err_d   = err | (ke_drdy_i & ~busy);
    done_d  = 1'b0;
    drdy_d  = 1'b0;
    key_en  = 1'b0;
    key_val = key_i;
    case (state)
      KSEQ_IDLE: begin
        if (key_load_i) begin
          state_d = KSEQ_READY;
          round_d = '0;
          key_en  = 1'b1;
        end else if (rk_req_i) err_d = 1'b1;
      end
      KSEQ_READY: begin
        if (key_load_i) begin
          round_d = '0;
          key_en  = 1'b1;
        end else if (rk_req_i && round == NR4) begin
          state_d = KSEQ_IDLE;
          done_d  = 1'b1;
        end else if (rk_req_i && (nv || arrive)) begin
          key_en  = 1'b1;
          key_val = nv ? shadow : ke_out_i;
          round_d = round + 4'd1;
        end else if (rk_req_i) begin
          state_d = KSEQ_EXPAND;
          drdy_d  = ~busy;
        end else drdy_d = PF & ~busy & ~nv & (round != NR4);
      end
      KSEQ_EXPAND: begin
        if (key_load_i || rk_req_i) err_d = 1'b1;
        if (ke_drdy_i && discard) drdy_d = 1'b1;
        else if (ke_drdy_i) begin
          state_d = KSEQ_READY;
          key_en  = 1'b1;
          key_val = ke_out_i;
          round_d = round + 4'(round != NR4);
        end
      end
      default: state_d = KSEQ_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= KSEQ_IDLE;
      round <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      drdy  <= 1'b0;
      first <= 1'b0;
    end else begin
      state <= state_d;
      round <= round_d;
      err   <= err_d;
      done  <= done_d;
      drdy  <= drdy_d;
      first <= state_d != KSEQ_IDLE && round_d == 4'd0;
    end
  assign rk_o             = key_q;
  assign ke_in_o          = key_q;
  assign rk_valid_o       = state == KSEQ_READY;
  assign rk_round_o       = round;
  assign done_o           = done;
  assign err_o            = err;
  assign ke_drdy_o        = drdy;
  assign ke_first_round_o = first;
endmodule

// File: tb/tb_rambam_key_sequencer.sv
// tb_rambam_key_sequencer: bench with a stub key_expansion returning in+1 per byte
module tb_rambam_key_sequencer;
  import rambam_key_sequencer_pkg::*;
  localparam int NR = 10;
  logic clk = 1'b0, rst = 1'b0, key_load_i = 1'b0, rk_req_i = 1'b0, spur = 1'b0;
  logic rk_valid_o, done_o, err_o, ke_drdy_o, ke_first_round_o, ke_drdy_i;
  logic [3:0] rk_round_o;
  logic [4:0] sr;
  round_key_t key_i = '0, rk_o, ke_in_o, ke_out_i, stub_q;
  int errors = 0, checks = 0, now = 0;

  rambam_key_sequencer #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .key_i(key_i), .key_load_i(key_load_i), .rk_o(rk_o),
    .rk_valid_o(rk_valid_o), .rk_round_o(rk_round_o), .rk_req_i(rk_req_i),
    .done_o(done_o), .err_o(err_o), .ke_in_o(ke_in_o), .ke_drdy_o(ke_drdy_o),
    .ke_first_round_o(ke_first_round_o), .ke_out_i(ke_out_i), .ke_drdy_i(ke_drdy_i)
  );

  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic round_key_t inc_key(input round_key_t k);
    round_key_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = k[i][j] + 1'b1;
    return r;
  endfunction
  function automatic round_key_t fill(input logic [7+d:0] v);
    round_key_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = v;
    return r;
  endfunction
  function automatic round_key_t rnd_key();
    round_key_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = (8+d)'($urandom);
    return r;
  endfunction

  // stub key_expansion: result appears five cycles after the drdy pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr     <= '0;
      stub_q <= '0;
    end else begin
      sr <= {sr[3:0], ke_drdy_o};
      if (ke_drdy_o) stub_q <= inc_key(ke_in_o);
    end
  assign ke_out_i  = stub_q;
  assign ke_drdy_i = sr[4] | spur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, now);
    end
  endtask
  task automatic chk_key(input string nm, input round_key_t act, input round_key_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, now);
    end
  endtask

  // reference schedule: a key becomes visible at a timestamp; expansion takes 7 cycles after a request
  bit m_active = 0, m_err = 0;
  int m_round = 0, m_valid_at = 0, m_done_at = -100;
  round_key_t m_cur = '0, m_nxt = '0;

  task automatic m_reset();
    m_active = 0; m_err = 0; m_round = 0; m_valid_at = 0; m_done_at = -100;
    m_cur = '0; m_nxt = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("rst_valid", rk_valid_o, 0);
    chk("rst_round", rk_round_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ke_drdy", ke_drdy_o, 0);
    chk("rst_first", ke_first_round_o, 0);
    chk_key("rst_rk", rk_o, '0);
    @(negedge clk);
    rst = 1'b0;
    now++;
    m_reset();
  endtask

  task automatic drv(input logic ld, input logic rq, input logic sp, input round_key_t k);
    key_load_i = ld; rk_req_i = rq; spur = sp; key_i = k;
    @(negedge clk);
    now++;
    key_load_i = 1'b0; rk_req_i = 1'b0; spur = 1'b0;
  endtask

  task automatic check_model();
    bit x;
    int er;
    round_key_t ek;
    x  = m_active && now < m_valid_at;
    er = x ? m_round - 1 : m_round;
    ek = x ? m_cur : m_nxt;
    chk("rk_valid", rk_valid_o, m_active && !x);
    chk("rk_round", rk_round_o, er);
    chk_key("rk", rk_o, ek);
    chk_key("ke_in", ke_in_o, ek);
    chk("ke_drdy", ke_drdy_o, x && now == m_valid_at - 6);
    chk("first_round", ke_first_round_o, m_active && er == 0);
    chk("done", done_o, now == m_done_at);
    chk("err", err_o, m_err);
  endtask

  task automatic model_step(input logic ld, input logic rq, input logic sp, input round_key_t k);
    bit x;
    x = m_active && now < m_valid_at;
    if (sp && !x) m_err = 1;
    if (ld) begin
      if (x) m_err = 1;
      else begin
        m_active = 1; m_round = 0; m_cur = k; m_nxt = k; m_valid_at = now + 1;
      end
    end else if (rq) begin
      if (!m_active || x) m_err = 1;
      else if (m_round == NR) begin
        m_active = 0; m_done_at = now + 1;
      end else begin
        m_cur = m_nxt; m_nxt = inc_key(m_nxt); m_round++; m_valid_at = now + 7;
      end
    end
  endtask

  task automatic cyc(input logic ld, input logic rq, input logic sp, input round_key_t k);
    check_model();
    model_step(ld, rq, sp, k);
    drv(ld, rq, sp, k);
  endtask

  task automatic req_wait();
    int n = 0;
    cyc(0, 1, 0, '0);
    while (!rk_valid_o && n < 20) begin
      cyc(0, 0, 0, '0);
      n++;
    end
    chk("req_wait_timeout", rk_valid_o, 1);
  endtask

  typedef struct {
    int          round;
    logic [31:0] byte_v;
    bit          first;
  } vec_t;
  vec_t tbl[NR+1];

  initial begin
    round_key_t k1, k2, k3, ke;
    int lat, pulses, r;
    bit x;
    for (int i = 0; i <= NR; i++) tbl[i] = '{i, 32'(5 + i), i == 0};
    @(negedge clk);
`ifndef KEY_PREFETCH_EN
    reset_dut();
    cyc(1, 0, 0, fill(10'h005));
    for (int i = 0; i <= NR; i++) begin
      chk("t1_valid", rk_valid_o, 1);
      chk("t1_round", rk_round_o, tbl[i].round);
      chk("t1_byte00", rk_o[0][0], tbl[i].byte_v);
      chk("t1_byte33", rk_o[3][3], tbl[i].byte_v);
      chk("t1_first", ke_first_round_o, tbl[i].first);
      cyc(0, 1, 0, '0);
      if (i < NR) begin
        lat = 1; pulses = 0;
        while (!rk_valid_o && lat < 20) begin
          pulses += int'(ke_drdy_o);
          cyc(0, 0, 0, '0);
          lat++;
        end
        chk("t2_latency", lat, 7);
        chk("t2_drdy_width", pulses, 1);
      end else begin
        chk("t1_done", done_o, 1);
        chk("t1_idle", rk_valid_o, 0);
      end
    end
    cyc(0, 0, 0, '0);
    chk("t1_done_pulse", done_o, 0);
    chk("t1_err", err_o, 0);
    // load during EXPAND is rejected; load in READY restarts
    reset_dut();
    k1 = rnd_key(); k2 = rnd_key(); k3 = rnd_key();
    cyc(1, 0, 0, k1);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(1, 0, 0, k2);
    lat = 0;
    while (!rk_valid_o && lat < 20) begin cyc(0, 0, 0, '0); lat++; end
    chk("t3_err", err_o, 1);
    chk("t3_round", rk_round_o, 1);
    chk_key("t3_key", rk_o, inc_key(k1));
    repeat (3) req_wait();
    chk("t3_round4", rk_round_o, 4);
    cyc(1, 0, 0, k3);
    chk("t3_reload_round", rk_round_o, 0);
    chk_key("t3_reload_key", rk_o, k3);
    // protocol errors
    reset_dut();
    cyc(0, 1, 0, '0);
    chk("t4_err_idle", err_o, 1);
    chk("t4_valid_idle", rk_valid_o, 0);
    reset_dut();
    cyc(1, 0, 0, k1);
    cyc(0, 0, 1, '0);
    chk("t4_err_spur", err_o, 1);
    chk("t4_spur_valid", rk_valid_o, 1);
    chk("t4_spur_round", rk_round_o, 0);
    repeat (3) cyc(0, 0, 0, '0);
    chk("t4_err_sticky", err_o, 1);
    cyc(1, 1, 0, k2);
    chk("t4_ld_req_drdy", ke_drdy_o, 0);
    chk("t4_ld_req_valid", rk_valid_o, 1);
    chk_key("t4_ld_req_key", rk_o, k2);
    // reset mid-expansion
    reset_dut();
    cyc(1, 0, 0, k1);
    repeat (3) req_wait();
    chk("t5_round3", rk_round_o, 3);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    reset_dut();
    cyc(1, 0, 0, k2);
    chk("t5_first", ke_first_round_o, 1);
    chk("t5_valid", rk_valid_o, 1);
    chk_key("t5_key", rk_o, k2);
    // random traffic against the reference schedule
    reset_dut();
    for (int it = 0; it < 600; it++) begin
      if (it % 150 == 149) reset_dut();
      x = m_active && now < m_valid_at;
      r = int'($urandom_range(99));
      if (x) cyc(r < 2, r >= 2 && r < 4, 0, rnd_key());
      else if (m_active) cyc(r < 5, r >= 5 && r < 40, r >= 97, rnd_key());
      else cyc(r < 30, r >= 30 && r < 33, r >= 97, rnd_key());
    end
    check_model();
`else
    reset_dut();
    k1 = rnd_key();
    ke = k1;
    drv(1, 0, 0, k1);
    repeat (7) begin
      chk("t6_valid_first", rk_valid_o, 1);
      drv(0, 0, 0, '0);
    end
    for (int i = 1; i <= NR; i++) begin
      drv(0, 1, 0, '0);
      ke = inc_key(ke);
      chk("t6_round", rk_round_o, i);
      chk_key("t6_key", rk_o, ke);
      repeat (7) begin
        chk("t6_valid", rk_valid_o, 1);
        drv(0, 0, 0, '0);
      end
    end
    drv(0, 1, 0, '0);
    chk("t6_done", done_o, 1);
    chk("t6_idle", rk_valid_o, 0);
    chk("t6_err", err_o, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
